// File: rtl/jelly_axi4s_frame_gate_ctl.sv
// jelly_axi4s_frame_gate_ctl
// Frame gate for an AXI4-Stream video path. It runs either continuously (ctl_enable)
// or for a single frame (ctl_oneshot). Frames are only ever let through whole:
// the gate discards beats until a start-of-frame, passes the stream combinationally
// until the configured number of lines has been seen, and then stops or re-arms.
// Line/blank parameters are captured at each frame start so the downstream image
// wrapper sees values that cannot change mid-frame.

module jelly_axi4s_frame_gate_ctl #(
    parameter int TUSER_WIDTH   = 1,
    parameter int TDATA_WIDTH   = 8,
    parameter int IMG_Y_WIDTH   = 9,
    parameter int BLANK_Y_WIDTH = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     ctl_enable,
    input  logic                     ctl_oneshot,

    input  logic [IMG_Y_WIDTH-1:0]   param_y_num,
    input  logic [BLANK_Y_WIDTH-1:0] param_blank_num,

    output logic [IMG_Y_WIDTH-1:0]   shadow_y_num,
    output logic [BLANK_Y_WIDTH-1:0] shadow_blank_num,

    output logic                     status_busy,
    output logic [CNT_WIDTH-1:0]     status_frame_count,
    output logic [CNT_WIDTH-1:0]     status_drop_count,
    output logic [CNT_WIDTH-1:0]     status_sof_err_count,

    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;

    localparam logic [IMG_Y_WIDTH-1:0] Y_ONE   = IMG_Y_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]               rstSync_q;
    logic                     runEn;

    logic [1:0]               state_q,      state_d;
    logic                     pending_q,    pending_d;
    logic [IMG_Y_WIDTH-1:0]   lineCnt_q,    lineCnt_d;
    logic                     midLine_q,    midLine_d;
    logic [IMG_Y_WIDTH-1:0]   shadowY_q,    shadowY_d;
    logic [BLANK_Y_WIDTH-1:0] shadowB_q,    shadowB_d;
    logic [CNT_WIDTH-1:0]     frameCnt_q,   frameCnt_d;
    logic [CNT_WIDTH-1:0]     dropCnt_q,    dropCnt_d;
    logic [CNT_WIDTH-1:0]     sofErrCnt_q,  sofErrCnt_d;

    logic                     sofIn;
    logic                     passHs;
    logic                     sofErr;
    logic [IMG_Y_WIDTH-1:0]   curLine;
    logic [IMG_Y_WIDTH-1:0]   lastLine;
    logic                     frameEnd;

    // Reset release is synchronised through two flops; assertion is immediate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign runEn = rstSync_q[1];

    // A mid-frame SOF restarts the line count, so the beat is treated as line 0.
    // A zero line count is treated as a one-line frame.
    always_comb begin
        sofIn    = s_axi4s_tuser[0];
        passHs   = (state_q == ST_PASS) & s_axi4s_tvalid & m_axi4s_tready;
        sofErr   = passHs & sofIn & ((lineCnt_q != '0) | midLine_q);
        curLine  = sofErr ? '0 : lineCnt_q;
        lastLine = (shadowY_q == '0) ? '0 : (shadowY_q - Y_ONE);
        frameEnd = passHs & s_axi4s_tlast & (curLine == lastLine);
    end

    // Next-state logic: state walk, oneshot latch, line tracking, shadows and counters.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | (ctl_oneshot & ~ctl_enable);
        lineCnt_d   = lineCnt_q;
        midLine_d   = midLine_q;
        shadowY_d   = shadowY_q;
        shadowB_d   = shadowB_q;
        frameCnt_d  = frameCnt_q;
        dropCnt_d   = dropCnt_q;
        sofErrCnt_d = sofErrCnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ctl_enable | pending_q) begin
                    state_d = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (s_axi4s_tvalid & sofIn) begin
                    state_d   = ST_PASS;
                    pending_d = ctl_oneshot & ~ctl_enable;
                    shadowY_d = param_y_num;
                    shadowB_d = param_blank_num;
                    lineCnt_d = '0;
                    midLine_d = 1'b0;
                end else if (s_axi4s_tvalid) begin
                    dropCnt_d = dropCnt_q + CNT_ONE;
                end
            end
            ST_PASS: begin
                if (passHs) begin
                    if (sofErr) begin
                        sofErrCnt_d = sofErrCnt_q + CNT_ONE;
                    end
                    if (s_axi4s_tlast) begin
                        midLine_d = 1'b0;
                        if (frameEnd) begin
                            frameCnt_d = frameCnt_q + CNT_ONE;
                            lineCnt_d  = '0;
                            state_d    = ctl_enable ? ST_SKIP : ST_IDLE;
                        end else begin
                            lineCnt_d = curLine + Y_ONE;
                        end
                    end else begin
                        midLine_d = 1'b1;
                        lineCnt_d = curLine;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; nothing moves until the synchronised reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            lineCnt_q   <= '0;
            midLine_q   <= 1'b0;
            shadowY_q   <= '0;
            shadowB_q   <= '0;
            frameCnt_q  <= '0;
            dropCnt_q   <= '0;
            sofErrCnt_q <= '0;
        end else if (runEn) begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            lineCnt_q   <= lineCnt_d;
            midLine_q   <= midLine_d;
            shadowY_q   <= shadowY_d;
            shadowB_q   <= shadowB_d;
            frameCnt_q  <= frameCnt_d;
            dropCnt_q   <= dropCnt_d;
            sofErrCnt_q <= sofErrCnt_d;
        end
    end

    // Handshake steering. In SKIP a SOF beat is held back (tready low) so it is the
    // first beat passed once the gate opens; every other beat is drained.
    always_comb begin
        s_axi4s_tready = 1'b0;
        m_axi4s_tvalid = 1'b0;
        case (state_q)
            ST_SKIP: s_axi4s_tready = ~(s_axi4s_tvalid & sofIn);
            ST_PASS: begin
                s_axi4s_tready = m_axi4s_tready;
                m_axi4s_tvalid = s_axi4s_tvalid;
            end
            default: begin
                s_axi4s_tready = 1'b0;
                m_axi4s_tvalid = 1'b0;
            end
        endcase
    end

    assign m_axi4s_tuser        = s_axi4s_tuser;
    assign m_axi4s_tlast        = s_axi4s_tlast;
    assign m_axi4s_tdata        = s_axi4s_tdata;

    assign shadow_y_num         = shadowY_q;
    assign shadow_blank_num     = shadowB_q;
    assign status_busy          = (state_q != ST_IDLE);
    assign status_frame_count   = frameCnt_q;
    assign status_drop_count    = dropCnt_q;
    assign status_sof_err_count = sofErrCnt_q;

endmodule

// File: tb/tb_jelly_axi4s_frame_gate_ctl.sv
// tb_jelly_axi4s_frame_gate_ctl
// Randomised source gaps and sink backpressure, with a frame-level reference
// model (lines remaining per frame, beats into the current line) checked every cycle.

module tb_jelly_axi4s_frame_gate_ctl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ctl_enable;
    logic       ctl_oneshot;
    logic [8:0] param_y_num;
    logic [7:0] param_blank_num;
    logic [8:0] shadow_y_num;
    logic [7:0] shadow_blank_num;
    logic       status_busy;
    logic [15:0] status_frame_count;
    logic [15:0] status_drop_count;
    logic [15:0] status_sof_err_count;
    logic [0:0] s_axi4s_tuser;
    logic       s_axi4s_tlast;
    logic [7:0] s_axi4s_tdata;
    logic       s_axi4s_tvalid;
    logic       s_axi4s_tready;
    logic [0:0] m_axi4s_tuser;
    logic       m_axi4s_tlast;
    logic [7:0] m_axi4s_tdata;
    logic       m_axi4s_tvalid;
    logic       m_axi4s_tready;

    jelly_axi4s_frame_gate_ctl dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .ctl_enable           (ctl_enable),
        .ctl_oneshot          (ctl_oneshot),
        .param_y_num          (param_y_num),
        .param_blank_num      (param_blank_num),
        .shadow_y_num         (shadow_y_num),
        .shadow_blank_num     (shadow_blank_num),
        .status_busy          (status_busy),
        .status_frame_count   (status_frame_count),
        .status_drop_count    (status_drop_count),
        .status_sof_err_count (status_sof_err_count),
        .s_axi4s_tuser        (s_axi4s_tuser),
        .s_axi4s_tlast        (s_axi4s_tlast),
        .s_axi4s_tdata        (s_axi4s_tdata),
        .s_axi4s_tvalid       (s_axi4s_tvalid),
        .s_axi4s_tready       (s_axi4s_tready),
        .m_axi4s_tuser        (m_axi4s_tuser),
        .m_axi4s_tlast        (m_axi4s_tlast),
        .m_axi4s_tdata        (m_axi4s_tdata),
        .m_axi4s_tvalid       (m_axi4s_tvalid),
        .m_axi4s_tready       (m_axi4s_tready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sof;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t       srcQ[$];
    logic [7:0]  dataSeq;
    bit          lastAcc;

    int          checks;
    int          errors;

    // Reference model: mode 0 = stopped, 1 = hunting for SOF, 2 = forwarding.
    int          mode;
    bit          pend;
    int          linesLeft;
    int          beatsInLine;
    int          relEdges;
    logic [8:0]  lockY;
    logic [7:0]  lockB;
    logic [15:0] frames;
    logic [15:0] drops;
    logic [15:0] sofErrs;

    int          passCount;
    bit          seenFirst;
    logic        firstTuser;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frameLines();
        return (lockY == 9'd0) ? 1 : int'(lockY);
    endfunction

    function automatic bit predReady();
        case (mode)
            1:       return !(s_axi4s_tvalid && s_axi4s_tuser[0]);
            2:       return m_axi4s_tready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mode = 0; pend = 0; linesLeft = 0; beatsInLine = 0; relEdges = 0;
        lockY = '0; lockB = '0; frames = '0; drops = '0; sofErrs = '0;
        passCount = 0; seenFirst = 0; firstTuser = 1'b0; lastAcc = 0;
    endtask

    // Advance the model over one rising edge using the inputs the DUT sees.
    task automatic modelEdge();
        bit acc;
        bit enterFwd;
        acc = 0;
        enterFwd = 0;
        if (!reset_n) begin
            relEdges = 0;
            lastAcc = 0;
            return;
        end
        if (relEdges < 2) begin
            relEdges++;
            lastAcc = 0;
            return;
        end
        acc = s_axi4s_tvalid && predReady();
        case (mode)
            0: if (ctl_enable || pend) mode = 1;
            1: begin
                if (s_axi4s_tvalid && s_axi4s_tuser[0]) begin
                    enterFwd    = 1;
                    mode        = 2;
                    lockY       = param_y_num;
                    lockB       = param_blank_num;
                    linesLeft   = frameLines();
                    beatsInLine = 0;
                end else if (s_axi4s_tvalid) begin
                    drops++;
                end
            end
            default: begin
                if (acc) begin
                    if (s_axi4s_tuser[0] && (linesLeft != frameLines() || beatsInLine != 0)) begin
                        sofErrs++;
                        linesLeft   = frameLines();
                        beatsInLine = 0;
                    end
                    if (s_axi4s_tlast) begin
                        linesLeft--;
                        beatsInLine = 0;
                        if (linesLeft == 0) begin
                            frames++;
                            mode = ctl_enable ? 1 : 0;
                        end
                    end else begin
                        beatsInLine++;
                    end
                end
            end
        endcase
        pend = (pend && !enterFwd) || (ctl_oneshot && !ctl_enable);
        if (acc) void'(srcQ.pop_front());
        lastAcc = acc;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic checkOutput();
        checkEq("s_tready", {31'd0, s_axi4s_tready}, {31'd0, predReady()});
        checkEq("m_tvalid", {31'd0, m_axi4s_tvalid}, {31'd0, (mode == 2) && s_axi4s_tvalid});
        checkEq("busy", {31'd0, status_busy}, {31'd0, mode != 0});
        if (mode == 2 && s_axi4s_tvalid && srcQ.size() > 0) begin
            checkEq("m_tdata", {24'd0, m_axi4s_tdata}, {24'd0, srcQ[0].data});
            checkEq("m_tuser", {31'd0, m_axi4s_tuser}, {31'd0, srcQ[0].sof});
            checkEq("m_tlast", {31'd0, m_axi4s_tlast}, {31'd0, srcQ[0].last});
        end
        checkEq("frame_count", {16'd0, status_frame_count}, {16'd0, frames});
        checkEq("drop_count", {16'd0, status_drop_count}, {16'd0, drops});
        checkEq("sof_err_count", {16'd0, status_sof_err_count}, {16'd0, sofErrs});
        checkEq("shadow_y", {23'd0, shadow_y_num}, {23'd0, lockY});
        checkEq("shadow_blank", {24'd0, shadow_blank_num}, {24'd0, lockB});
        if (m_axi4s_tvalid && m_axi4s_tready) begin
            passCount++;
            if (!seenFirst) begin
                seenFirst  = 1;
                firstTuser = m_axi4s_tuser[0];
            end
        end
    endtask

    task automatic driveSource();
        m_axi4s_tready = ($urandom_range(0, 3) != 0);
        if (s_axi4s_tvalid && !lastAcc) return;
        if (srcQ.size() > 0 && $urandom_range(0, 3) != 0) begin
            s_axi4s_tvalid = 1'b1;
            s_axi4s_tuser  = srcQ[0].sof;
            s_axi4s_tlast  = srcQ[0].last;
            s_axi4s_tdata  = srcQ[0].data;
        end else begin
            s_axi4s_tvalid = 1'b0;
            s_axi4s_tuser  = 1'($urandom);
            s_axi4s_tlast  = 1'($urandom);
            s_axi4s_tdata  = 8'($urandom);
        end
    endtask

    // One cycle: compare at the falling edge, update model at the rising edge, then drive.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
        driveSource();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic addLines(input int w, input int h, input bit withSof);
        beat_t b;
        for (int l = 0; l < h; l++) begin
            for (int x = 0; x < w; x++) begin
                b.sof  = withSof && (l == 0) && (x == 0);
                b.last = (x == w - 1);
                b.data = dataSeq;
                dataSeq++;
                srcQ.push_back(b);
            end
        end
    endtask

    task automatic applyReset();
        reset_n        = 1'b0;
        ctl_enable     = 1'b0;
        ctl_oneshot    = 1'b0;
        s_axi4s_tvalid = 1'b0;
        srcQ.delete();
        modelReset();
        run(3);
        reset_n = 1'b1;
        run(3);
    endtask

    task automatic pulseOneshot();
        ctl_oneshot = 1'b1;
        applyStimulus();
        ctl_oneshot = 1'b0;
    endtask

    task automatic waitLine(input int target, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (mode == 2 && frames == 16'd0 && linesLeft == target) ok = 1;
            else applyStimulus();
        end
        checkEq(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int total;
        checks = 0; errors = 0; dataSeq = 8'h10;
        reset_n = 1'b1; ctl_enable = 1'b0; ctl_oneshot = 1'b0;
        param_y_num = 9'd4; param_blank_num = 8'd2;
        s_axi4s_tvalid = 1'b0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = '0;
        m_axi4s_tready = 1'b1;
        modelReset();

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        checkEq("rst_s_tready", {31'd0, s_axi4s_tready}, 32'd0);
        checkEq("rst_m_tvalid", {31'd0, m_axi4s_tvalid}, 32'd0);
        checkEq("rst_busy", {31'd0, status_busy}, 32'd0);
        checkEq("rst_frames", {16'd0, status_frame_count}, 32'd0);
        checkEq("rst_shadow_y", {23'd0, shadow_y_num}, 32'd0);
        run(2);
        reset_n = 1'b1;
        run(4);

        // Oneshot: four 8x4 frames queued, exactly one passes.
        param_y_num = 9'd4; param_blank_num = 8'd2;
        for (int f = 0; f < 4; f++) addLines(8, 4, 1);
        run(4);
        pulseOneshot();
        run(300);
        checkEq("os_passed", passCount, 32'd32);
        checkEq("os_frames", {16'd0, status_frame_count}, 32'd1);
        checkEq("os_busy", {31'd0, status_busy}, 32'd0);
        checkEq("os_stalled", {31'd0, s_axi4s_tready}, 32'd0);
        checkEq("os_shadow_y", {23'd0, shadow_y_num}, 32'd4);
        checkEq("os_shadow_b", {24'd0, shadow_blank_num}, 32'd2);

        // Mid-stream start: three tail beats are dropped before the SOF.
        applyReset();
        param_y_num = 9'd2; param_blank_num = 8'd7;
        addLines(3, 1, 0);
        addLines(4, 2, 1);
        ctl_enable = 1'b1;
        run(200);
        checkEq("mid_drops", {16'd0, status_drop_count}, 32'd3);
        checkEq("mid_first_sof", {31'd0, firstTuser}, 32'd1);
        checkEq("mid_frames", {16'd0, status_frame_count}, 32'd1);

        // Param change mid-frame: shadow follows only at the next SOF.
        applyReset();
        param_y_num = 9'd4; param_blank_num = 8'd3;
        addLines(4, 4, 1);
        addLines(4, 6, 1);
        ctl_enable = 1'b1;
        waitLine(2, "pc_reach_line2");
        param_y_num = 9'd6;
        applyStimulus();
        checkEq("pc_shadow_hold", {23'd0, shadow_y_num}, 32'd4);
        run(400);
        checkEq("pc_shadow_new", {23'd0, shadow_y_num}, 32'd6);
        checkEq("pc_frames", {16'd0, status_frame_count}, 32'd2);

        // Disable at line 1 (plus an oneshot that must be ignored while enabled).
        applyReset();
        param_y_num = 9'd4; param_blank_num = 8'd1;
        addLines(5, 4, 1);
        addLines(5, 4, 1);
        ctl_enable = 1'b1;
        waitLine(3, "dis_reach_line1");
        pulseOneshot();
        ctl_enable = 1'b0;
        run(300);
        checkEq("dis_frames", {16'd0, status_frame_count}, 32'd1);
        checkEq("dis_busy", {31'd0, status_busy}, 32'd0);
        checkEq("dis_stalled", {31'd0, s_axi4s_tready}, 32'd0);

        // Random-width frames under random backpressure.
        applyReset();
        param_y_num = 9'd3; param_blank_num = 8'($urandom);
        total = 0;
        for (int f = 0; f < 5; f++) begin
            int w;
            w = $urandom_range(1, 6);
            addLines(w, 3, 1);
            total += 3 * w;
        end
        ctl_enable = 1'b1;
        run(600);
        ctl_enable = 1'b0;
        run(10);
        checkEq("bp_passed", passCount, total);
        checkEq("bp_frames", {16'd0, status_frame_count}, 32'd5);

        // Early SOF at line 2: frame ends four lines after the injected SOF.
        applyReset();
        param_y_num = 9'd4;
        addLines(4, 2, 1);
        addLines(4, 4, 1);
        pulseOneshot();
        run(300);
        checkEq("es_sof_err", {16'd0, status_sof_err_count}, 32'd1);
        checkEq("es_passed", passCount, 32'd24);
        checkEq("es_frames", {16'd0, status_frame_count}, 32'd1);

        // Zero line count behaves as a one-line frame.
        applyReset();
        param_y_num = 9'd0;
        addLines(3, 1, 1);
        addLines(3, 1, 1);
        pulseOneshot();
        run(100);
        checkEq("y0_frames", {16'd0, status_frame_count}, 32'd1);
        checkEq("y0_passed", passCount, 32'd3);

        // Reset mid-frame abandons it; release takes effect on the third edge.
        applyReset();
        param_y_num = 9'd4;
        addLines(4, 4, 1);
        ctl_enable = 1'b1;
        waitLine(2, "rm_reach_line2");
        reset_n = 1'b0;
        #1;
        checkEq("rm_frames", {16'd0, status_frame_count}, 32'd0);
        checkEq("rm_busy", {31'd0, status_busy}, 32'd0);
        checkEq("rm_s_tready", {31'd0, s_axi4s_tready}, 32'd0);
        s_axi4s_tvalid = 1'b0;
        srcQ.delete();
        modelReset();
        run(2);
        reset_n = 1'b1;
        addLines(4, 4, 1);
        run(2);
        checkEq("rm_sync_idle", {31'd0, status_busy}, 32'd0);
        applyStimulus();
        checkEq("rm_sync_start", {31'd0, status_busy}, 32'd1);
        run(200);
        checkEq("rm_frames_after", {16'd0, status_frame_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jelly_axi4s_frame_gate_ctl.md
JELLY_AXI4S_FRAME_GATE_CTL -- requirements
Module: jelly_axi4s_frame_gate_ctl

Interface
REQ-001 SHALL have parameter TUSER_WIDTH, default 1: AXI4-Stream tuser width; tuser[0] is start-of-frame (SOF).
REQ-002 SHALL have parameter TDATA_WIDTH, default 8: pixel data width.
REQ-003 SHALL have parameter IMG_Y_WIDTH, default 9: line counter width.
REQ-004 SHALL have parameter BLANK_Y_WIDTH, default 8: blank line parameter width.
REQ-005 SHALL have parameter CNT_WIDTH, default 16: status counter width.
REQ-006 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port ctl_enable  in  1  continuous-run request, level.
REQ-009 SHALL have port ctl_oneshot  in  1  single-frame request, one-cycle pulse.
REQ-010 SHALL have port param_y_num  in  IMG_Y_WIDTH  lines per frame, live value.
REQ-011 SHALL have port param_blank_num  in  BLANK_Y_WIDTH  blank lines, live value.
REQ-012 SHALL have port shadow_y_num  out  IMG_Y_WIDTH  frame-locked line count, to the image wrapper.
REQ-013 SHALL have port shadow_blank_num  out  BLANK_Y_WIDTH  frame-locked blank count, to the image wrapper.
REQ-014 SHALL have port status_busy  out  1  high when state is not IDLE.
REQ-015 SHALL have port status_frame_count  out  CNT_WIDTH  completed frames.
REQ-016 SHALL have port status_drop_count  out  CNT_WIDTH  beats discarded in SKIP.
REQ-017 SHALL have port status_sof_err_count  out  CNT_WIDTH  SOF beats seen mid-frame.
REQ-018 SHALL have ports s_axi4s_tuser/tlast/tdata/tvalid  in  TUSER_WIDTH/1/TDATA_WIDTH/1, and s_axi4s_tready  out  1: upstream stream.
REQ-019 SHALL have ports m_axi4s_tuser/tlast/tdata/tvalid  out  TUSER_WIDTH/1/TDATA_WIDTH/1, and m_axi4s_tready  in  1: downstream stream to the image wrapper.

Function
REQ-020 SHALL implement the states IDLE, SKIP and PASS.
REQ-021 SHALL latch a pending-oneshot flag on ctl_oneshot. The flag clears when the block enters PASS.
REQ-022 IDLE: s_tready=0 and m_tvalid=0. Go to SKIP when ctl_enable or the pending-oneshot flag is set.
REQ-023 SKIP: s_tready=1 and m_tvalid=0.
  - A beat with tvalid & !tuser[0] is discarded and increments drop_count.
  - A beat with tvalid & tuser[0] is not consumed; the block goes to PASS on the next cycle.
REQ-024 On the SKIP->PASS transition, the block SHALL load shadow_y_num/shadow_blank_num from the param inputs and clear line_cnt. Shadows SHALL be stable at all other times.
REQ-025 PASS: combinational pass-through. m_tdata/tuser/tlast/tvalid = s_*, and s_tready = m_tready. Latency 0.
REQ-026 PASS SHALL increment line_cnt on each tlast handshake (tvalid & tready & tlast).
REQ-027 Frame end is the tlast handshake with line_cnt == shadow_y_num-1. On frame end:
  - frame_count increments.
  - Next state is SKIP if ctl_enable, otherwise IDLE.
REQ-028 A handshake in PASS with tuser[0]=1 while line_cnt!=0, or after a non-tlast beat of line 0, SHALL:
  - increment sof_err_count;
  - be passed downstream;
  - restart line_cnt at 0;
  - leave the shadows unchanged.
REQ-029 Deasserting ctl_enable mid-frame SHALL NOT truncate the frame. The block stops only at frame end.
REQ-030 If shadow_y_num==0, it SHALL be treated as 1 (frame end on first tlast).
REQ-031 All counters SHALL wrap modulo 2^CNT_WIDTH; line_cnt is IMG_Y_WIDTH bits.
REQ-032 ctl_oneshot SHALL be ignored for counting purposes when ctl_enable is already high; at most one pending oneshot is held.
REQ-033 m_axi4s_tvalid SHALL never assert outside PASS.
REQ-034 tdata/tuser/tlast SHALL be stable while tvalid & !tready.

Reset
REQ-035 While reset_n=0, the block SHALL be in state IDLE with:
  - pending flag, line_cnt and all status counters = 0;
  - shadow_y_num = 0 and shadow_blank_num = 0;
  - s_tready = 0, m_tvalid = 0, status_busy = 0.
REQ-036 Reset assertion SHALL take effect immediately (asynchronous). Release SHALL be synchronised: first state change no earlier than the second clk edge after release.
REQ-037 Reset asserted mid-frame SHALL abandon the frame without incrementing frame_count.

Verification
REQ-038 Oneshot: y_num=4, blank=2, 8x4 frames streamed, one pulse.
  - Exactly 32 beats pass and frame_count=1.
  - Block returns to IDLE and upstream is stalled.
  - shadow_y_num=4 and shadow_blank_num=2.
REQ-039 Mid-stream start: enable asserted mid-frame (3 beats before next SOF). drop_count=3, and the first passed beat has tuser[0]=1.
REQ-040 Param change: param_y_num changed 4->6 during a frame. shadow_y_num stays 4 until the next SOF, then reads 6.
REQ-041 Disable: enable dropped at line 1 of 4. The frame completes (frame_count+1), then the block goes to IDLE with s_tready=0.
REQ-042 Downstream backpressure: m_tready toggles randomly. Output beats match input order with no loss or duplication, and the REQ-034 stability rule holds.
REQ-043 Early SOF: SOF injected at line 2. sof_err_count=1, line_cnt restarts, and the frame ends 4 lines after the injected SOF.
